// File: rtl/seg7_display_driver.sv
// Binary-to-decimal driver for a multiplexed common-anode 7-segment display.
// Sequential shift-add-3 conversion, atomic display load, refresh scan and leading-zero blanking.
module seg7_display_driver #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] value,
  input  logic                  blank_en,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  busy
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned PRE_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0]    cap_q;
  logic [DATA_WIDTH-1:0]    shift_q;
  logic [DIGITS-1:0][3:0]   work_bcd;
  logic                     work_ovf;
  logic [CNT_W-1:0]         bit_cnt;
  logic [DIGITS-1:0][3:0]   disp_bcd;
  logic                     disp_ovf;
  logic [PRE_W-1:0]         presc;
  logic [IDX_W-1:0]         idx_q;

  logic                     start_c;
  logic                     shift_c;
  logic                     load_c;
  logic [DIGITS-1:0][3:0]   adj_c;
  logic [DIGITS-1:0]        lz_c;
  logic [6:0]               seg_c;
  logic [DIGITS-1:0]        an_c;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = SEG_DASH;
    endcase
  endfunction

  // Conversion FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Conversion FSM next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (value != cap_q) state_next = SHIFT;
      SHIFT:   if (bit_cnt == '0) state_next = LOAD;
      LOAD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Conversion FSM datapath controls
  always_comb begin
    start_c = 1'b0;
    shift_c = 1'b0;
    load_c  = 1'b0;
    case (state)
      IDLE:    start_c = (value != cap_q);
      SHIFT:   shift_c = 1'b1;
      LOAD:    load_c  = 1'b1;
      default: ;
    endcase
  end

  // Add-3 correction of every working nibble ahead of the shift
  always_comb begin
    adj_c = work_bcd;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (work_bcd[i] >= 4'd5) adj_c[i] = work_bcd[i] + 4'd3;
    end
  end

  // Conversion datapath and atomic display load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_q    <= '0;
      shift_q  <= '0;
      work_bcd <= '0;
      work_ovf <= 1'b0;
      bit_cnt  <= '0;
      disp_bcd <= '0;
      disp_ovf <= 1'b0;
      busy     <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      if (start_c) begin
        cap_q    <= value;
        shift_q  <= value;
        work_bcd <= '0;
        work_ovf <= 1'b0;
        bit_cnt  <= CNT_LAST;
      end
      if (shift_c) begin
        {work_bcd, shift_q} <= {adj_c, shift_q} << 1;
        if (adj_c[DIGITS-1][3]) work_ovf <= 1'b1;
        bit_cnt <= bit_cnt - CNT_W'(1);
      end
      if (load_c) begin
        disp_bcd <= work_bcd;
        disp_ovf <= work_ovf;
      end
    end
  end

  // Refresh prescaler and digit index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      idx_q <= '0;
    end else if (presc == PRE_LAST) begin
      presc <= '0;
      idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end else begin
      presc <= presc + PRE_W'(1);
    end
  end

  // lz_c[i]: digit i and every digit above it are zero
  always_comb begin
    lz_c = '1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      for (int j = i; j < int'(DIGITS); j++) begin
        if (disp_bcd[j] != 4'd0) lz_c[i] = 1'b0;
      end
    end
  end

  // Pattern for the currently scanned digit; overflow dashes override blanking
  always_comb begin
    an_c = ~(DIGITS'(1) << idx_q);
    if (disp_ovf)
      seg_c = SEG_DASH;
    else if (blank_en && (idx_q != '0) && lz_c[idx_q])
      seg_c = SEG_BLANK;
    else
      seg_c = decode(disp_bcd[idx_q]);
  end

  // Registered display pins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg <= SEG_ZERO;
      an  <= ~DIGITS'(1);
    end else begin
      seg <= seg_c;
      an  <= an_c;
    end
  end

endmodule
